exc_ctrl: RTL and testbench

//  Commit-point exception/interrupt controller and CP0 register file for the 5-stage MIPS core.

---
 rtl/exc_ctrl_pkg.sv | 32 +++
 rtl/exc_arb.sv | 33 +++
 rtl/exc_ctrl.sv | 117 +++++++++++
 tb/tb_exc_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, CP0 register numbers and field packing helpers
// for the commit-point exception controller.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // The controller state is SR.EXL itself.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } exl_state_t;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    return {16'b0, im, 8'b0, exl, ie};
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] code);
    return {bd, 15'b0, ip, 3'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/exc_arb.sv
// Combinational arbiter: interrupt > exception > ERET > MTC0, deciding which
// commit-point event wins in the current cycle.
module exc_arb
  import exc_ctrl_pkg::*;
(
  input  logic       m_valid,
  input  logic       sr_ie,
  input  logic       sr_exl,
  input  logic [5:0] sr_im,
  input  logic [5:0] hwint,
  input  logic [4:0] m_exccode,
  input  logic       m_eret,
  input  logic       cp0_we,
  output logic       exc_flush,
  output logic       eret_flush,
  output logic       cp0_commit,
  output logic [4:0] exc_code
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req    = m_valid & sr_ie & ~sr_exl & (|(hwint & sr_im));
    exc_req    = m_valid & ~sr_exl & (m_exccode != 5'd0);
    exc_flush  = int_req | exc_req;
    eret_flush = m_valid & m_eret & ~exc_flush;
    // A trapping instruction never commits, so its MTC0 is dropped.
    cp0_commit = cp0_we & ~exc_flush & ~eret_flush;
    exc_code   = int_req ? EXC_INT : m_exccode;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Commit-point exception/interrupt controller and CP0 register file
// (SR, Cause, EPC, PRId) with handler entry and ERET sequencing.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic        m_eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_flush,
  output logic        eret_flush,
  output logic [31:0] exc_target,
  output logic [31:0] epc,
  output logic        exl
);

  exl_state_t  state_q, state_d;
  logic        sr_ie_q, sr_ie_d;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_code_q, cause_code_d;
  logic [31:0] epc_q, epc_d;

  logic        cp0_commit;
  logic [4:0]  arb_code;

  exc_arb u_arb (
    .m_valid    (m_valid),
    .sr_ie      (sr_ie_q),
    .sr_exl     (state_q == ST_HANDLER),
    .sr_im      (sr_im_q),
    .hwint      (hwint),
    .m_exccode  (m_exccode),
    .m_eret     (m_eret),
    .cp0_we     (cp0_we),
    .exc_flush  (exc_flush),
    .eret_flush (eret_flush),
    .cp0_commit (cp0_commit),
    .exc_code   (arb_code)
  );

  always_comb begin
    state_d      = state_q;
    sr_ie_d      = sr_ie_q;
    sr_im_d      = sr_im_q;
    cause_bd_d   = cause_bd_q;
    cause_code_d = cause_code_q;
    epc_d        = epc_q;
    cause_ip_d   = hwint;
    if (exc_flush) begin
      state_d      = ST_HANDLER;
      epc_d        = m_bd ? (m_pc - 32'd4) : m_pc;
      cause_bd_d   = m_bd;
      cause_code_d = arb_code;
    end else if (eret_flush) begin
      state_d = ST_RUN;
    end else if (cp0_commit) begin
      case (cp0_addr)
        CP0_SR: begin
          sr_im_d = cp0_wdata[15:10];
          sr_ie_d = cp0_wdata[0];
          state_d = cp0_wdata[1] ? ST_HANDLER : ST_RUN;
        end
        CP0_EPC: epc_d = cp0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      sr_ie_q      <= 1'b0;
      sr_im_q      <= 6'd0;
      cause_bd_q   <= 1'b0;
      cause_ip_q   <= 6'd0;
      cause_code_q <= 5'd0;
      epc_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      sr_ie_q      <= sr_ie_d;
      sr_im_q      <= sr_im_d;
      cause_bd_q   <= cause_bd_d;
      cause_ip_q   <= cause_ip_d;
      cause_code_q <= cause_code_d;
      epc_q        <= epc_d;
    end
  end

  // MFC0 reads the registered values, so a same-cycle MTC0 is not visible.
  always_comb begin
    case (cp0_addr)
      CP0_SR:    cp0_rdata = pack_sr(sr_im_q, state_q == ST_HANDLER, sr_ie_q);
      CP0_CAUSE: cp0_rdata = pack_cause(cause_bd_q, cause_ip_q, cause_code_q);
      CP0_EPC:   cp0_rdata = epc_q;
      CP0_PRID:  cp0_rdata = PRID_VALUE;
      default:   cp0_rdata = 32'd0;
    endcase
  end

  assign exc_target = HANDLER_ADDR;
  assign epc        = epc_q;
  assign exl        = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios followed by randomized cycles, all
// checked against a word-level model of SR/Cause/EPC.
module tb_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [5:0]  hwint;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic        eret_flush;
  logic [31:0] exc_target;
  logic [31:0] epc;
  logic        exl;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] md_sr, md_cause, md_epc;
  logic        s_exc, s_eret;
  logic [31:0] s_rdata, s_epc;

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hwint      (hwint),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exccode  (m_exccode),
    .m_eret     (m_eret),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .exc_flush  (exc_flush),
    .eret_flush (eret_flush),
    .exc_target (exc_target),
    .epc        (epc),
    .exl        (exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at negedge against the model, advance the model.
  task automatic cycle(input logic rst, input logic [5:0] hw, input logic v,
                       input logic [31:0] pc, input logic bd, input logic [4:0] code,
                       input logic er, input logic we, input logic [4:0] addr,
                       input logic [31:0] wd);
    logic        irq, exq, e_exc, e_eret;
    logic [31:0] e_rd, bd_bit, code_bits;
    reset = rst; hwint = hw; m_valid = v; m_pc = pc; m_bd = bd; m_exccode = code;
    m_eret = er; cp0_we = we; cp0_addr = addr; cp0_wdata = wd;
    irq    = v && md_sr[0] && !md_sr[1] && ((hw & md_sr[15:10]) != 6'd0);
    exq    = v && !md_sr[1] && (code != 5'd0);
    e_exc  = irq || exq;
    e_eret = v && er && !e_exc;
    case (addr)
      5'd12:   e_rd = md_sr;
      5'd13:   e_rd = md_cause;
      5'd14:   e_rd = md_epc;
      5'd15:   e_rd = PRID;
      default: e_rd = 32'd0;
    endcase
    @(negedge clk);
    s_exc = exc_flush; s_eret = eret_flush; s_rdata = cp0_rdata; s_epc = epc;
    chk("exc_target", exc_target, HANDLER);
    chk("epc", epc, md_epc);
    chk("exl", 32'(exl), 32'(md_sr[1]));
    if (!rst) begin
      chk("exc_flush", 32'(exc_flush), 32'(e_exc));
      chk("eret_flush", 32'(eret_flush), 32'(e_eret));
      chk("cp0_rdata", cp0_rdata, e_rd);
    end
    if (rst) begin
      md_sr = 32'd0; md_cause = 32'd0; md_epc = 32'd0;
    end else begin
      bd_bit    = md_cause & 32'h8000_0000;
      code_bits = md_cause & 32'h0000_007C;
      if (e_exc) begin
        md_epc    = bd ? pc - 32'd4 : pc;
        bd_bit    = bd ? 32'h8000_0000 : 32'd0;
        code_bits = irq ? 32'd0 : ({27'd0, code} << 2);
        md_sr     = md_sr | 32'h2;
        exp_q.push_back(md_epc);
      end else if (e_eret) begin
        md_sr = md_sr & ~32'h2;
      end else if (we) begin
        if (addr == 5'd12) md_sr = wd & 32'h0000_FC03;
        else if (addr == 5'd14) md_epc = wd;
      end
      md_cause = bd_bit | ({26'd0, hw} << 10) | code_bits;
    end
    @(posedge clk);
    #1;
    if (!rst && e_exc) chk("epc_trap", epc, exp_q.pop_front());
  endtask

  task automatic rd(input logic [4:0] addr);
    cycle(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, addr, 32'd0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    cycle(1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1, addr, wd);
  endtask

  initial begin
    logic [4:0] codes[4];
    logic [4:0] r_code, r_addr;
    codes[0] = 5'd4; codes[1] = 5'd5; codes[2] = 5'd10; codes[3] = 5'd12;
    reset = 1'b1; hwint = 6'd0; m_valid = 1'b0; m_pc = 32'd0; m_bd = 1'b0;
    m_exccode = 5'd0; m_eret = 1'b0; cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
    md_sr = 32'd0; md_cause = 32'd0; md_epc = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rd(5'd12); chk("rst_sr", s_rdata, 32'd0);
    rd(5'd13); chk("rst_cause", s_rdata, 32'd0);
    rd(5'd14); chk("rst_epc", s_rdata, 32'd0);
    chk("rst_flush", 32'({s_exc, s_eret}), 32'd0);

    // 1: unmasked interrupt
    wr(5'd12, 32'h0000_0401);
    cycle(1'b0, 6'b000001, 1'b1, 32'h3010, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t1_flush", 32'(s_exc), 32'd1);
    chk("t1_epc", epc, 32'h3010);
    chk("t1_exl", 32'(exl), 32'd1);
    cycle(1'b0, 6'b000001, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd13, 32'd0);
    chk("t1_cause", s_rdata, 32'h0000_0400);

    // 2: AdEL in a delay slot
    wr(5'd12, 32'd0);
    cycle(1'b0, 6'd0, 1'b1, 32'h3004, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t2_flush", 32'(s_exc), 32'd1);
    chk("t2_epc", epc, 32'h3000);
    rd(5'd13); chk("t2_cause", s_rdata, 32'h8000_0010);

    // 3: ERET, then ERET with a live unmasked interrupt
    wr(5'd14, 32'h3008);
    cycle(1'b0, 6'd0, 1'b1, 32'h3100, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t3_eret", 32'(s_eret), 32'd1);
    chk("t3_epc_out", s_epc, 32'h3008);
    chk("t3_exl", 32'(exl), 32'd0);
    wr(5'd12, 32'h0000_0403);
    cycle(1'b0, 6'b000001, 1'b1, 32'h3104, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("t3b_noexc", 32'(s_exc), 32'd0);
    chk("t3b_eret", 32'(s_eret), 32'd1);

    // 4: interrupt beats a simultaneous MTC0 to EPC
    cycle(1'b0, 6'b000001, 1'b1, 32'h3020, 1'b0, 5'd0, 1'b0, 1'b1, 5'd14, 32'h1234);
    chk("t4_flush", 32'(s_exc), 32'd1);
    chk("t4_epc", epc, 32'h3020);
    rd(5'd14); chk("t4_rd_epc", s_rdata, 32'h3020);

    // 5: pending interrupt waits through bubbles
    wr(5'd12, 32'h0000_0401);
    cycle(1'b0, 6'b000001, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t5_bub1", 32'(s_exc), 32'd0);
    cycle(1'b0, 6'b000001, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t5_bub2", 32'(s_exc), 32'd0);
    cycle(1'b0, 6'b000001, 1'b1, 32'h3030, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t5_flush", 32'(s_exc), 32'd1);
    chk("t5_epc", epc, 32'h3030);

    // 6: reset while in the handler, then PRId and an unmapped register
    chk("t6_pre_exl", 32'(exl), 32'd1);
    cycle(1'b1, 6'b111111, 1'b1, 32'h3040, 1'b0, 5'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("t6_exl", 32'(exl), 32'd0);
    chk("t6_epc", epc, 32'd0);
    rd(5'd12); chk("t6_sr", s_rdata, 32'd0);
    rd(5'd13); chk("t6_cause", s_rdata, 32'd0);
    rd(5'd15); chk("t6_prid", s_rdata, PRID);
    rd(5'd7);  chk("t6_reg7", s_rdata, 32'd0);

    // Randomized cycles against the model
    for (int i = 0; i < 500; i++) begin
      r_code = ($urandom_range(3) == 0) ? codes[$urandom_range(3)] : 5'd0;
      case ($urandom_range(3))
        0:       r_addr = 5'd12;
        1:       r_addr = 5'd13;
        2:       r_addr = 5'd14;
        default: r_addr = 5'($urandom);
      endcase
      cycle(($urandom_range(63) == 0), ($urandom_range(2) == 0) ? 6'($urandom) : 6'd0,
            1'($urandom), $urandom, 1'($urandom), r_code,
            ($urandom_range(7) == 0), ($urandom_range(3) == 0), r_addr,
            ($urandom_range(1) == 0) ? 32'h0000_FC01 : $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
